load_store_unit: RTL

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/riscv_pkg.sv | 52 +++++
 rtl/lsu_align.sv | 49 ++++
 rtl/load_store_unit.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions: opcodes, load/store size encodings and LSU state.
// Also holds the small legality/alignment helpers used by the load/store unit.
package riscv_pkg;

    typedef enum logic [6:0] {
        OP_LOAD   = 7'b0000011,
        OP_STORE  = 7'b0100011,
        OP_OP     = 7'b0110011,
        OP_OP_IMM = 7'b0010011,
        OP_BRANCH = 7'b1100011,
        OP_JAL    = 7'b1101111,
        OP_JALR   = 7'b1100111,
        OP_LUI    = 7'b0110111,
        OP_AUIPC  = 7'b0010111
    } opcode_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        WAIT = 2'b10,
        RESP = 2'b11
    } lsu_state_e;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    function automatic logic load_legal(input logic [2:0] f3);
        return (f3 == LB) || (f3 == LH) || (f3 == LW) || (f3 == LBU) || (f3 == LHU);
    endfunction

    function automatic logic store_legal(input logic [2:0] f3);
        return (f3 == SB) || (f3 == SH) || (f3 == SW);
    endfunction

    // funct3[1:0] is the access size for every legal encoding.
    function automatic logic is_aligned(input logic [2:0] f3, input logic [1:0] lo);
        logic ok;
        case (f3[1:0])
            2'b00:   ok = 1'b1;
            2'b01:   ok = ~lo[0];
            default: ok = (lo == 2'b00);
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for the load/store unit: byte enables, store data
// replication and load lane extraction with sign/zero extension.
module lsu_align
    import riscv_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata_word,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic [31:0] load_data
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        be        = 4'b1111;
        wdata_rep = wdata;
        load_data = rdata_word;
        lane_b    = rdata_word[{addr_lo, 3'b000} +: 8];
        lane_h    = rdata_word[{addr_lo[1], 4'b0000} +: 16];

        case (funct3[1:0])
            2'b00: begin
                be        = 4'b0001 << addr_lo;
                wdata_rep = {4{wdata[7:0]}};
            end
            2'b01: begin
                be        = 4'b0011 << addr_lo;
                wdata_rep = {2{wdata[15:0]}};
            end
            default: begin
                be        = 4'b1111;
                wdata_rep = wdata;
            end
        endcase

        case (funct3)
            LB:      load_data = {{24{lane_b[7]}}, lane_b};
            LH:      load_data = {{16{lane_h[15]}}, lane_h};
            LBU:     load_data = {24'd0, lane_b};
            LHU:     load_data = {16'd0, lane_h};
            default: load_data = rdata_word;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one access at a time from the pipeline, runs the
// memory request/grant/rvalid sequence with a timeout, and returns one response.
module load_store_unit
    import riscv_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  mem_w,
    input  logic        is_load,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        rsp_valid,
    output logic [31:0] rdata,
    output logic        err,
    output logic        stall,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output lsu_state_e  state_dbg
);

    // Handshakes: an access transfers on req_valid && req_ready; a memory
    // request transfers on dmem_req && dmem_gnt and completes on dmem_rvalid
    // in WAIT; rsp_valid is a single-cycle pulse with no back-pressure.

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    lsu_state_e     state_q, state_d;
    logic [2:0]     funct3_q;
    logic           store_en_q;
    logic           is_load_q;
    logic [31:0]    addr_q;
    logic [31:0]    wdata_q;
    logic [CW-1:0]  cnt_q;
    logic [31:0]    rdata_q;
    logic           err_q;

    logic [2:0]     f3_in;
    logic           st_in;
    logic           access_in;
    logic           legal_in;
    logic           aligned_in;
    logic           go_mem;
    logic           bad_in;

    logic [3:0]     be_a;
    logic [31:0]    wdata_a;
    logic [31:0]    load_a;

    assign f3_in = mem_w[3:1];
    assign st_in = mem_w[0];

    // Requesting both a load and a store is treated as illegal.
    always_comb begin
        access_in  = is_load | st_in;
        legal_in   = is_load ? (~st_in & load_legal(f3_in))
                             : (~st_in | store_legal(f3_in));
        aligned_in = is_aligned(f3_in, addr[1:0]);
        go_mem     = access_in & legal_in & aligned_in;
        bad_in     = ~legal_in | (access_in & ~aligned_in);
    end

    lsu_align u_align (
        .funct3     (funct3_q),
        .addr_lo    (addr_q[1:0]),
        .wdata      (wdata_q),
        .rdata_word (dmem_rdata),
        .be         (be_a),
        .wdata_rep  (wdata_a),
        .load_data  (load_a)
    );

    always_comb begin
        state_d    = state_q;
        req_ready  = 1'b0;
        stall      = 1'b1;
        rsp_valid  = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        dmem_addr  = '0;
        dmem_be    = '0;
        dmem_wdata = '0;

        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                stall     = 1'b0;
                if (req_valid) begin
                    state_d = go_mem ? REQ : RESP;
                end
            end
            REQ: begin
                dmem_req   = 1'b1;
                dmem_we    = store_en_q;
                dmem_addr  = {addr_q[31:2], 2'b00};
                dmem_be    = be_a;
                dmem_wdata = store_en_q ? wdata_a : '0;
                if (dmem_gnt) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // rvalid on the last counted cycle still completes normally.
                if (dmem_rvalid || (cnt_q == CNT_LAST)) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            funct3_q   <= '0;
            store_en_q <= 1'b0;
            is_load_q  <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            cnt_q      <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        funct3_q   <= f3_in;
                        store_en_q <= st_in;
                        is_load_q  <= is_load;
                        addr_q     <= addr;
                        wdata_q    <= wdata;
                        rdata_q    <= '0;
                        err_q      <= bad_in;
                    end
                end
                REQ: begin
                    if (dmem_gnt) begin
                        cnt_q <= '0;
                    end
                end
                WAIT: begin
                    if (dmem_rvalid) begin
                        rdata_q <= is_load_q ? load_a : '0;
                        err_q   <= 1'b0;
                    end else if (cnt_q == CNT_LAST) begin
                        rdata_q <= '0;
                        err_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign rdata     = rdata_q;
    assign err       = err_q;
    assign state_dbg = state_q;

endmodule
